uart_host_if: RTL and testbench
===============================

UART_HOST_IF -- requirements
Module: uart_host_if

Interface
REQ-001 SHALL have port clk_bus, input, 1 bit: 28 MHz bus clock; all logic is on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port data_wr, input, 1 bit: CPU write strobe, one clk_bus wide per access.
REQ-004 SHALL have port data_in, input, 8 bits: CPU write byte, valid while data_wr=1.
REQ-005 SHALL have port data_rd, input, 1 bit: CPU data-read strobe, one clk_bus wide.
REQ-006 SHALL have port data_out, output, 8 bits: RX FIFO head byte.
REQ-007 SHALL have port status_out, output, 8 bits: status register.
REQ-008 SHALL have port txdata, output, 8 bits: byte to the UART transmitter.
REQ-009 SHALL have port txbegin, output, 1 bit: transmit request to the UART.
REQ-010 SHALL have port txbusy, input, 1 bit: UART transmitter busy.
REQ-011 SHALL have port rxdata, input, 8 bits: byte from the UART receiver.
REQ-012 SHALL have port rxrecv, input, 1 bit: UART receiver holds a byte.
REQ-013 SHALL have port data_read, output, 1 bit: acknowledge to the UART receiver.

Function
REQ-014 SHALL provide a 16-entry TX FIFO with 5-bit count; data_wr pushes data_in when count<16 (pre-edge value); a write to a full FIFO is dropped silently.
REQ-015 SHALL run the TX FSM T_IDLE->T_LOAD->T_WBUSY->T_WDONE->T_IDLE.
REQ-016 In T_IDLE, when the FIFO is non-empty and txbusy=0, the FSM SHALL pop the head into txdata and go to T_LOAD.
REQ-017 In T_LOAD, txbegin SHALL be 1 for exactly one cycle; the FSM then goes to T_WBUSY.
REQ-018 In T_WBUSY, txbegin SHALL be 0; the FSM waits for txbusy=1, then goes to T_WDONE.
REQ-019 In T_WDONE, the FSM SHALL wait for txbusy=0, then go to T_IDLE; txdata stays stable from T_LOAD until T_IDLE.
REQ-020 A CPU push and an FSM pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-021 SHALL run the RX FSM R_IDLE->R_ACK->R_IDLE.
REQ-022 In R_IDLE, when rxrecv=1 and the RX FIFO is not full, the FSM SHALL push rxdata, drive data_read=1 for one cycle and go to R_ACK.
REQ-023 In R_ACK, data_read SHALL be 0; the FSM waits for rxrecv=0, then goes to R_IDLE.
REQ-024 While the RX FIFO is full, the FSM SHALL NOT acknowledge; the byte stays in the UART (backpressure, no loss inside this block).
REQ-025 data_out SHALL be the combinational RX FIFO head (first-word fall-through), or 0x00 when the FIFO is empty.
REQ-026 data_rd SHALL pop when the RX FIFO is non-empty and be ignored when it is empty.
REQ-027 An RX push and a data_rd pop in the same cycle SHALL both take effect.
REQ-028 status_out SHALL be {rx_avail, tx_full, tx_idle, rx_count[4:0]}:
 - rx_avail = RX count != 0;
 - tx_full = TX count == 16;
 - tx_idle = TX FIFO empty, TX FSM in T_IDLE and txbusy=0.
REQ-029 status_out SHALL be combinational from registered state; FIFO pointers wrap modulo 16.

Reset
REQ-030 While rst_n=0 at a clk_bus edge, the block SHALL clear both FIFOs (counts and pointers to 0), put both FSMs in idle, and set txbegin=0, data_read=0, txdata=0x00.
REQ-031 After reset, data_out SHALL be 0x00 and status_out SHALL be 0x20 (tx_idle=1 only if txbusy=0, otherwise 0x00).
REQ-032 On reset mid-transfer, a UART byte already in flight is not aborted; the next txbegin SHALL wait for txbusy=0 (REQ-016).
REQ-033 On reset mid-transfer, a pending rxrecv SHALL be re-acknowledged normally after reset.

Configuration
REQ-034 Macro UART_RX_FIFO_EN defined: the RX buffer SHALL be the 16-entry FIFO described above.
REQ-035 Macro UART_RX_FIFO_EN undefined: the RX buffer SHALL be a single holding register; full = count==1, and rx_count is 0 or 1.
REQ-036 TX FIFO depth SHALL be unaffected by the macro.

Verification
REQ-037 Write 0x55 with an idle UART model: txdata=0x55 and a single 1-cycle txbegin 1 cycle later; tx_idle returns to 1 after txbusy falls.
REQ-038 Write 17 bytes 0x00..0x10 back-to-back with txbusy held 1: 0x10 dropped, tx_full=1, bytes emitted in order 0x00..0x0F.
REQ-039 Model presents 0xA5 on rxrecv: data_read pulses once; status_out=0x81; data_out=0xA5; after data_rd, status_out shows rx_avail=0, count 0.
REQ-040 Fill RX with 16 bytes (macro on) or 1 byte (macro off) and present one more: no data_read until a data_rd pop; the extra byte is then accepted.
REQ-041 Assert rst_n=0 during T_WDONE with txbusy=1 and 3 bytes queued: FIFO empty after reset; no txbegin until txbusy=0 and a new write.
REQ-042 Same-cycle data_rd and RX push with count=5: count stays 5 and the order is preserved.

Source files
------------

// File: rtl/uart_host_if.sv
// CPU-side UART host interface: 16-entry TX FIFO feeding a txbegin/txbusy handshake FSM,
// and an RX buffer filled by an rxrecv/data_read ack FSM. Define UART_RX_FIFO_EN for a
// 16-entry RX FIFO; without it the RX buffer is a single holding register.

module uart_host_if (
   input  logic       clk_bus,
   input  logic       rst_n,
   input  logic       data_wr,
   input  logic [7:0] data_in,
   input  logic       data_rd,
   output logic [7:0] data_out,
   output logic [7:0] status_out,
   output logic [7:0] txdata,
   output logic       txbegin,
   input  logic       txbusy,
   input  logic [7:0] rxdata,
   input  logic       rxrecv,
   output logic       data_read
);

   // state   | meaning
   // T_IDLE  | waiting for a queued byte and a free transmitter
   // T_LOAD  | txbegin pulse, txdata holds the popped byte
   // T_WBUSY | waiting for the transmitter to report busy
   // T_WDONE | waiting for the transmitter to finish the byte
   // R_IDLE  | waiting for a received byte and room to store it
   // R_ACK   | byte stored, waiting for rxrecv to drop

   typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WBUSY, T_WDONE} tx_state_t;
   typedef enum logic       {R_IDLE, R_ACK} rx_state_t;

   tx_state_t  tx_state;
   rx_state_t  rx_state;

   logic [7:0] tx_mem [16];
   logic [3:0] tx_wr_ptr;
   logic [3:0] tx_rd_ptr;
   logic [4:0] tx_count;
   logic       tx_push;
   logic       tx_pop;
   logic       tx_idle;

   logic [4:0] rx_count;
   logic       rx_full;
   logic       rx_push;
   logic       rx_pop;
   logic [7:0] rx_head;

   assign tx_push = data_wr && (tx_count != 5'd16);
   assign tx_pop  = (tx_state == T_IDLE) && (tx_count != 5'd0) && !txbusy;

   always_ff @(posedge clk_bus) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         tx_wr_ptr <= 4'd0;
         tx_rd_ptr <= 4'd0;
         tx_count  <= 5'd0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 4'd1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 4'd1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 5'd1;
            2'b01:   tx_count <= tx_count - 5'd1;
            default: tx_count <= tx_count;
         endcase
      end
   end

   // A byte already in the UART at reset keeps txbusy high; T_IDLE simply waits it out.
   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         tx_state <= T_IDLE;
         txbegin  <= 1'b0;
         txdata   <= 8'h00;
      end else begin
         case (tx_state)
            T_IDLE: begin
               if (tx_pop) begin
                  txdata   <= tx_mem[tx_rd_ptr];
                  txbegin  <= 1'b1;
                  tx_state <= T_LOAD;
               end
            end
            T_LOAD: begin
               txbegin  <= 1'b0;
               tx_state <= T_WBUSY;
            end
            T_WBUSY: if (txbusy)  tx_state <= T_WDONE;
            T_WDONE: if (!txbusy) tx_state <= T_IDLE;
            default: tx_state <= T_IDLE;
         endcase
      end
   end

   assign rx_push = (rx_state == R_IDLE) && rxrecv && !rx_full;
   assign rx_pop  = data_rd && (rx_count != 5'd0);

`ifdef UART_RX_FIFO_EN
   logic [7:0] rx_mem [16];
   logic [3:0] rx_wr_ptr;
   logic [3:0] rx_rd_ptr;

   assign rx_full = (rx_count == 5'd16);
   assign rx_head = rx_mem[rx_rd_ptr];

   always_ff @(posedge clk_bus) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rxdata;
   end

   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         rx_wr_ptr <= 4'd0;
         rx_rd_ptr <= 4'd0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 4'd1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 4'd1;
      end
   end
`else
   logic [7:0] rx_hold;

   assign rx_full = (rx_count == 5'd1);
   assign rx_head = rx_hold;

   always_ff @(posedge clk_bus) begin
      if (!rst_n)       rx_hold <= 8'h00;
      else if (rx_push) rx_hold <= rxdata;
   end
`endif

   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         rx_count <= 5'd0;
      end else begin
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 5'd1;
            2'b01:   rx_count <= rx_count - 5'd1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   // Full RX buffer holds off the ack, so the byte waits inside the UART.
   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         rx_state  <= R_IDLE;
         data_read <= 1'b0;
      end else begin
         case (rx_state)
            R_IDLE: begin
               if (rx_push) begin
                  data_read <= 1'b1;
                  rx_state  <= R_ACK;
               end
            end
            R_ACK: begin
               data_read <= 1'b0;
               if (!rxrecv) rx_state <= R_IDLE;
            end
         endcase
      end
   end

   assign tx_idle    = (tx_count == 5'd0) && (tx_state == T_IDLE) && !txbusy;
   assign data_out   = (rx_count != 5'd0) ? rx_head : 8'h00;
   assign status_out = {(rx_count != 5'd0), (tx_count == 5'd16), tx_idle, rx_count};

endmodule

// File: tb/tb_uart_host_if.sv
// Scoreboard bench for uart_host_if: behavioural UART TX/RX models, queue-based
// expected streams, directed corner cases followed by a randomized traffic phase.

module tb_uart_host_if;

`ifdef UART_RX_FIFO_EN
   localparam int RX_DEPTH = 16;
`else
   localparam int RX_DEPTH = 1;
`endif

   logic       clk_bus;
   logic       rst_n;
   logic       data_wr;
   logic [7:0] data_in;
   logic       data_rd;
   logic [7:0] data_out;
   logic [7:0] status_out;
   logic [7:0] txdata;
   logic       txbegin;
   logic       txbusy;
   logic [7:0] rxdata;
   logic       rxrecv;
   logic       data_read;

   bit hold_busy;
   bit model_busy;
   bit model_en;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] tx_exp [$];
   logic [7:0] rx_model [$];
   logic [7:0] rx_src [$];
   logic [7:0] rx_cur;
   int tx_pushed  = 0;
   int tx_seen    = 0;
   int rd_pulses  = 0;

   assign txbusy = hold_busy | model_busy;

   uart_host_if dut (
      .clk_bus   (clk_bus),
      .rst_n     (rst_n),
      .data_wr   (data_wr),
      .data_in   (data_in),
      .data_rd   (data_rd),
      .data_out  (data_out),
      .status_out(status_out),
      .txdata    (txdata),
      .txbegin   (txbegin),
      .txbusy    (txbusy),
      .rxdata    (rxdata),
      .rxrecv    (rxrecv),
      .data_read (data_read)
   );

   initial begin
      clk_bus = 1'b0;
      forever #5 clk_bus = ~clk_bus;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] exp_status(input int rxc, input bit txfull, input bit txidle);
      return {(rxc != 0), txfull, txidle, 5'(rxc)};
   endfunction

   // monitor: pops the TX scoreboard on every txbegin, records accepted RX bytes on data_read
   initial begin : monitor
      bit prev_txbegin;
      bit prev_data_read;
      prev_txbegin   = 1'b0;
      prev_data_read = 1'b0;
      forever begin
         @(negedge clk_bus);
         if (txbegin) begin
            check("txbegin_width", int'(prev_txbegin), 0);
            if (tx_exp.size() == 0) begin
               total_cnt++;
               $display("FAIL tx_spurious: txbegin with txdata=0x%02h, expected no transmit", txdata);
            end else begin
               check("txdata_order", int'(txdata), int'(tx_exp.pop_front()));
            end
            tx_seen++;
         end
         if (data_read) begin
            check("data_read_width", int'(prev_data_read), 0);
            rx_model.push_back(rx_cur);
            rd_pulses++;
         end
         prev_txbegin   = txbegin;
         prev_data_read = data_read;
      end
   end

   initial begin : uart_tx_model
      model_busy = 1'b0;
      forever begin
         @(negedge clk_bus);
         if (txbegin && model_en) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_bus);
            #1 model_busy = 1'b1;
            repeat ($urandom_range(1, 6)) @(posedge clk_bus);
            #1 model_busy = 1'b0;
         end
      end
   end

   initial begin : uart_rx_model
      bit got;
      rxrecv = 1'b0;
      rxdata = 8'h00;
      rx_cur = 8'h00;
      forever begin
         @(posedge clk_bus);
         #1;
         if (rx_src.size() > 0) begin
            rx_cur = rx_src.pop_front();
            rxdata = rx_cur;
            rxrecv = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 3000 && !got; t++) begin
               @(negedge clk_bus);
               if (data_read) got = 1'b1;
            end
            if (!got) begin
               total_cnt++;
               $display("FAIL rx_ack_timeout: byte 0x%02h never acknowledged, expected data_read", rx_cur);
            end
            @(posedge clk_bus);
            #1;
            rxrecv = 1'b0;
            rxdata = 8'($urandom);
         end
      end
   end

   task automatic cpu_burst(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_bus);
         #1;
         data_wr = 1'b1;
         data_in = first + 8'(i);
         if (tx_pushed - tx_seen < 16) begin
            tx_exp.push_back(data_in);
            tx_pushed++;
         end
      end
      @(posedge clk_bus);
      #1;
      data_wr = 1'b0;
   endtask

   task automatic cpu_read();
      @(negedge clk_bus);
      #1;
      if (rx_model.size() > 0) begin
         check("data_out_head", int'(data_out), int'(rx_model.pop_front()));
         @(posedge clk_bus);
         #1;
         data_rd = 1'b1;
         @(posedge clk_bus);
         #1;
         data_rd = 1'b0;
      end
   endtask

   task automatic wait_rx_level(input int n, input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 500 && !ok; t++) begin
         @(negedge clk_bus);
         #1;
         if (rx_model.size() == n) ok = 1'b1;
      end
      if (!ok) begin
         total_cnt++;
         $display("FAIL %s: rx level %0d, expected %0d", name, rx_model.size(), n);
      end
   endtask

   task automatic wait_tx_drain(input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 3000 && !ok; t++) begin
         @(negedge clk_bus);
         #1;
         if (tx_exp.size() == 0 && !txbusy && status_out[5]) ok = 1'b1;
      end
      if (!ok) begin
         total_cnt++;
         $display("FAIL %s: %0d bytes still pending, expected TX drained", name, tx_exp.size());
      end
   endtask

   initial begin : stimulus
      int base;
      int r;
      bit done;
      rst_n     = 1'b0;
      data_wr   = 1'b0;
      data_in   = 8'h00;
      data_rd   = 1'b0;
      hold_busy = 1'b0;
      model_en  = 1'b1;

      repeat (3) @(posedge clk_bus);
      @(negedge clk_bus);
      check("reset_status", int'(status_out), 8'h20);
      check("reset_data_out", int'(data_out), 8'h00);
      check("reset_txbegin", int'(txbegin), 0);
      check("reset_data_read", int'(data_read), 0);
      check("reset_txdata", int'(txdata), 8'h00);
      @(posedge clk_bus);
      #1 rst_n = 1'b1;

      // single write, idle UART: txbegin one cycle after the accepting edge
      cpu_burst(8'h55, 1);
      @(negedge clk_bus);
      check("txbegin_not_yet", int'(txbegin), 0);
      @(negedge clk_bus);
      check("txbegin_1cyc", int'(txbegin), 1);
      check("txdata_55", int'(txdata), 8'h55);
      @(negedge clk_bus);
      check("txbegin_single", int'(txbegin), 0);
      wait_tx_drain("drain_55");
      check("tx_idle_after_55", int'(status_out), int'(exp_status(0, 1'b0, 1'b1)));

      // 17 back-to-back writes with the UART held busy: last one dropped
      hold_busy = 1'b1;
      cpu_burst(8'h00, 17);
      @(negedge clk_bus);
      #1;
      check("tx_full_status", int'(status_out), int'(exp_status(0, 1'b1, 1'b0)));
      repeat (10) @(posedge clk_bus);
      #1 hold_busy = 1'b0;
      wait_tx_drain("drain_17");
      check("status_after_17", int'(status_out), int'(exp_status(0, 1'b0, 1'b1)));

      // one RX byte with TX side busy
      hold_busy = 1'b1;
      base = rd_pulses;
      rx_src.push_back(8'hA5);
      wait_rx_level(1, "rx_a5_level");
      repeat (5) @(posedge clk_bus);
      check("rx_a5_acks", rd_pulses - base, 1);
      @(negedge clk_bus);
      #1;
      check("rx_a5_status", int'(status_out), 8'h81);
      check("rx_a5_data_out", int'(data_out), 8'hA5);
      cpu_read();
      @(negedge clk_bus);
      #1;
      check("rx_a5_status_empty", int'(status_out), 8'h00);
      check("rx_a5_data_out_empty", int'(data_out), 8'h00);
      hold_busy = 1'b0;

      // RX full backpressure
      for (int i = 0; i < RX_DEPTH; i++) rx_src.push_back(8'($urandom));
      wait_rx_level(RX_DEPTH, "rx_fill");
      base = rd_pulses;
      rx_src.push_back(8'hE7);
      repeat (30) @(posedge clk_bus);
      #1;
      check("rx_full_no_ack", rd_pulses - base, 0);
      check("rx_full_rxrecv_held", int'(rxrecv), 1);
      check("rx_full_status", int'(status_out), int'(exp_status(RX_DEPTH, 1'b0, 1'b1)));
      cpu_read();
      wait_rx_level(RX_DEPTH, "rx_refill");
      check("rx_extra_acked", rd_pulses - base, 1);
      for (int i = 0; i < RX_DEPTH; i++) cpu_read();
      repeat (4) @(posedge clk_bus);
      @(negedge clk_bus);
      #1;
      check("rx_drained_status", int'(status_out), 8'h20);

`ifdef UART_RX_FIFO_EN
      // simultaneous RX push and CPU pop at count 5
      for (int i = 0; i < 5; i++) rx_src.push_back(8'(8'h10 + i));
      wait_rx_level(5, "rx_five");
      repeat (4) @(posedge clk_bus);
      @(posedge clk_bus);
      rx_src.push_back(8'h5A);
      #1;
      check("rx_same_cycle_head", int'(data_out), int'(rx_model.pop_front()));
      data_rd = 1'b1;
      @(posedge clk_bus);
      #1 data_rd = 1'b0;
      wait_rx_level(5, "rx_same_cycle_level");
      @(negedge clk_bus);
      #1;
      check("rx_same_cycle_count", int'(status_out), int'(exp_status(5, 1'b0, 1'b1)));
      for (int i = 0; i < 5; i++) cpu_read();
`endif

      // reset in T_WDONE with three bytes queued and the UART still busy
      model_en = 1'b0;
      base = tx_seen;
      cpu_burst(8'hC0, 4);
      for (int t = 0; t < 50 && tx_seen == base; t++) @(posedge clk_bus);
      check("wdone_first_sent", tx_seen - base, 1);
      #1 hold_busy = 1'b1;
      repeat (3) @(posedge clk_bus);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk_bus);
      #1 rst_n = 1'b1;
      tx_exp.delete();
      tx_pushed = tx_seen;
      @(negedge clk_bus);
      check("rst_mid_status", int'(status_out), int'(exp_status(0, 1'b0, 1'b0)));
      check("rst_mid_txdata", int'(txdata), 8'h00);
      repeat (20) @(posedge clk_bus);
      #1 hold_busy = 1'b0;
      repeat (10) @(posedge clk_bus);
      @(negedge clk_bus);
      #1;
      check("rst_mid_empty_status", int'(status_out), 8'h20);
      model_en = 1'b1;
      cpu_burst(8'h3C, 1);
      wait_tx_drain("drain_after_reset");

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3 && tx_pushed - tx_seen < 16) cpu_burst(8'($urandom), 1);
         else if (r < 6 && rx_model.size() > 0) cpu_read();
         else if (r < 8 && rx_src.size() < 2) rx_src.push_back(8'($urandom));
         else begin
            @(posedge clk_bus);
            #1;
         end
      end
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         if (rx_model.size() > 0) cpu_read();
         else if (rx_src.size() == 0 && !rxrecv) done = 1'b1;
         else begin
            @(posedge clk_bus);
            #1;
         end
      end
      wait_tx_drain("drain_random");
      repeat (4) @(posedge clk_bus);
      @(negedge clk_bus);
      #1;
      check("final_status", int'(status_out), 8'h20);
      check("final_data_out", int'(data_out), 8'h00);
      check("final_tx_pending", tx_exp.size(), 0);
      check("final_rx_pending", rx_model.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
